d1_fetch_queue: RTL and testbench
=================================

D1_FETCH_QUEUE -- requirements
Module: d1_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of F2->D1 entries; SHALL be a power of two in 2..16.
REQ-002 Parameter RESET_PC, default 32'hBFC00000, initial restart PC.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; SHALL be applied immediately and released synchronously by the environment.
REQ-005 F2_Issued  in  1  push request; F2 slot holds a valid instruction.
REQ-006 F2_Instruction / F2_FetchPC / F2_PCAdd4  in  32 each  entry payload.
REQ-007 F2_IsBDS / F2_Exception / F2_XOP_Restart  in  1 each; F2_ExcCode  in  5  entry payload.
REQ-008 D1_Stall  in  1  decode cannot consume the head entry this cycle.
REQ-009 D1_Flush  in  1  discard all entries.
REQ-010 D1_F2Issued  out  1  head entry valid.
REQ-011 D1_Instruction / D1_PCAdd4  out  32 each; D1_F2IsBDS / D1_F2Exception / D1_XOP_Restart  out  1 each; D1_F2ExcCode  out  5  head payload.
REQ-012 D1_FetchPC  out  32  restart PC of the head entry.
REQ-013 F2_QueueFull  out  1  count == DEPTH.
REQ-014 D1_Count  out  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-015 Storage: circular buffer with read and write pointers of $clog2(DEPTH) bits, each wrapping DEPTH-1 -> 0.
REQ-016 Pop = D1_F2Issued & ~D1_Stall & ~D1_Flush; the head advances at the clock edge.
REQ-017 Push = F2_Issued & ~D1_Flush & (~F2_QueueFull | pop); push while full with a simultaneous pop SHALL be accepted.
REQ-018 Push while full without a pop SHALL be dropped, and state SHALL be unchanged.
REQ-019 Count: push only +1; pop only -1; push and pop together leaves it unchanged.
REQ-020 Latency: an entry pushed at edge N SHALL appear on the D1_* outputs after edge N (registered storage, combinational head read).
REQ-021 Flush: at the next edge, pointers and count SHALL go to 0; any same-cycle push SHALL be discarded; D1_Flush SHALL override D1_Stall.
REQ-022 Restart tracking: a register last_pc SHALL load F2_FetchPC on every accepted push with F2_IsBDS=0.
REQ-023 Restart PC of a pushed entry SHALL be F2_FetchPC if F2_IsBDS=0, else the current last_pc (the preceding branch PC).
REQ-024 Flush SHALL NOT alter last_pc.
REQ-025 When empty: D1_F2Issued=0; D1_FetchPC=last_pc; all other D1_* payload outputs SHALL be 0.
REQ-026 Head outputs SHALL be stable while D1_Stall=1 and no flush occurs.

Reset
REQ-027 On reset: pointers=0, count=0, last_pc=RESET_PC, D1_F2Issued=0, F2_QueueFull=0, D1_Count=0, D1_FetchPC=RESET_PC, other outputs 0.
REQ-028 Storage array SHALL NOT be reset; reset mid-operation discards all entries without one stale output cycle.

Configuration
REQ-029 Macro D1_FETCH_QUEUE_BYPASS_EN.
- Defined: when empty and F2_Issued=1, the D1_* outputs SHALL show the F2 entry combinationally in the same cycle, with restart PC per REQ-023.
- If additionally ~D1_Stall, the entry SHALL be consumed without being written (count stays 0).
- If D1_Stall, the entry SHALL be written normally.
REQ-030 Macro undefined: no combinational F2->D1 path; latency per REQ-020.

Verification
REQ-031 Reset, then push 4 instrs PC 0x100..0x10C with D1_Stall=1 -> D1_Count=4, F2_QueueFull=1; a 5th push is dropped; release stall -> 0x100..0x10C pop in order over 4 cycles.
REQ-032 Full queue, push and pop in the same cycle -> count stays 4, new entry becomes tail; run 10 cycles to exercise pointer wrap, FIFO order preserved.
REQ-033 Push branch PC 0x200 (IsBDS=0), then BDS PC 0x204 (IsBDS=1) -> BDS entry D1_FetchPC=0x200; the following non-BDS entry at 0x300 -> D1_FetchPC=0x300.
REQ-034 3 entries queued, D1_Flush=1 with D1_Stall=1 and F2_Issued=1 -> next cycle count=0, D1_F2Issued=0, D1_FetchPC=last_pc.
REQ-035 Reset asserted mid-stream with 2 entries -> outputs go immediately to reset values, D1_FetchPC=0xBFC00000.
REQ-036 With D1_FETCH_QUEUE_BYPASS_EN, empty queue, push 0x400 with D1_Stall=0 -> same-cycle D1_F2Issued=1, D1_Instruction=F2_Instruction, count remains 0.

Source files
------------

// File: rtl/d1_fetch_queue.sv
// d1_fetch_queue: F2->D1 instruction queue with restart-PC tracking for branch delay slots.
// Optional macro D1_FETCH_QUEUE_BYPASS_EN: an empty queue shows the F2 entry combinationally.
// Ports:
//   clock, reset            - rising-edge clock, async active-high reset
//   F2_* (inputs)           - push request and entry payload from fetch stage 2
//   D1_Stall, D1_Flush      - decode hold / discard-all controls
//   D1_* (outputs)          - head entry (valid, payload, restart PC)
//   F2_QueueFull, D1_Count  - occupancy status
module d1_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     F2_Issued,
    input  logic [31:0]              F2_Instruction,
    input  logic [31:0]              F2_FetchPC,
    input  logic [31:0]              F2_PCAdd4,
    input  logic                     F2_IsBDS,
    input  logic                     F2_Exception,
    input  logic                     F2_XOP_Restart,
    input  logic [4:0]               F2_ExcCode,
    input  logic                     D1_Stall,
    input  logic                     D1_Flush,
    output logic                     D1_F2Issued,
    output logic [31:0]              D1_Instruction,
    output logic [31:0]              D1_PCAdd4,
    output logic                     D1_F2IsBDS,
    output logic                     D1_F2Exception,
    output logic                     D1_XOP_Restart,
    output logic [4:0]               D1_F2ExcCode,
    output logic [31:0]              D1_FetchPC,
    output logic                     F2_QueueFull,
    output logic [$clog2(DEPTH):0]   D1_Count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   r_instr [DEPTH];
    logic [31:0]   r_pcadd4[DEPTH];
    logic [31:0]   r_rpc   [DEPTH];
    logic          r_bds   [DEPTH];
    logic          r_exc   [DEPTH];
    logic          r_xop   [DEPTH];
    logic [4:0]    r_code  [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_last_pc;

    logic          w_empty;
    logic          w_full;
    logic          w_byp;
    logic          w_take;
    logic          w_pop;
    logic          w_push;
    logic          w_wr;
    logic          w_rd;
    logic [31:0]   w_rpc_in;

    assign w_empty  = r_cnt == '0;
    assign w_full   = r_cnt == CW'(DEPTH);
    // A delay-slot entry restarts at the branch that precedes it.
    assign w_rpc_in = F2_IsBDS ? r_last_pc : F2_FetchPC;

`ifdef D1_FETCH_QUEUE_BYPASS_EN
    assign w_byp = w_empty & F2_Issued;
`else
    assign w_byp = 1'b0;
`endif

    // A bypassed entry consumed in the same cycle never touches storage.
    assign w_take = w_byp & ~D1_Stall & ~D1_Flush;
    assign w_pop  = D1_F2Issued & ~D1_Stall & ~D1_Flush;
    assign w_push = F2_Issued & ~D1_Flush & (~w_full | w_pop);
    assign w_wr   = w_push & ~w_take;
    assign w_rd   = w_pop & ~w_empty;

    always_comb begin
        D1_F2Issued    = ~w_empty | w_byp;
        D1_Instruction = ~w_empty ? r_instr[r_rd]  : (w_byp ? F2_Instruction : '0);
        D1_PCAdd4      = ~w_empty ? r_pcadd4[r_rd] : (w_byp ? F2_PCAdd4 : '0);
        D1_F2IsBDS     = ~w_empty ? r_bds[r_rd]    : (w_byp & F2_IsBDS);
        D1_F2Exception = ~w_empty ? r_exc[r_rd]    : (w_byp & F2_Exception);
        D1_XOP_Restart = ~w_empty ? r_xop[r_rd]    : (w_byp & F2_XOP_Restart);
        D1_F2ExcCode   = ~w_empty ? r_code[r_rd]   : (w_byp ? F2_ExcCode : '0);
        D1_FetchPC     = ~w_empty ? r_rpc[r_rd]    : (w_byp ? w_rpc_in : r_last_pc);
        F2_QueueFull   = w_full;
        D1_Count       = r_cnt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd      <= '0;
            r_wr      <= '0;
            r_cnt     <= '0;
            r_last_pc <= RESET_PC;
        end else begin
            if (D1_Flush) begin
                r_rd  <= '0;
                r_wr  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_rd)
                    r_rd <= r_rd + AW'(1);
                if (w_wr)
                    r_wr <= r_wr + AW'(1);
                r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
            end
            if (w_push & ~F2_IsBDS)
                r_last_pc <= F2_FetchPC;
        end
    end

    // Storage is not reset; validity comes solely from r_cnt.
    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_instr[r_wr]  <= F2_Instruction;
            r_pcadd4[r_wr] <= F2_PCAdd4;
            r_rpc[r_wr]    <= w_rpc_in;
            r_bds[r_wr]    <= F2_IsBDS;
            r_exc[r_wr]    <= F2_Exception;
            r_xop[r_wr]    <= F2_XOP_Restart;
            r_code[r_wr]   <= F2_ExcCode;
        end
    end
endmodule

// File: tb/tb_d1_fetch_queue.sv
// tb_d1_fetch_queue: directed self-checking bench for d1_fetch_queue.
module tb_d1_fetch_queue;
    logic        clock = 1'b0;
    logic        reset;
    logic        F2_Issued;
    logic [31:0] F2_Instruction;
    logic [31:0] F2_FetchPC;
    logic [31:0] F2_PCAdd4;
    logic        F2_IsBDS;
    logic        F2_Exception;
    logic        F2_XOP_Restart;
    logic [4:0]  F2_ExcCode;
    logic        D1_Stall;
    logic        D1_Flush;
    logic        D1_F2Issued;
    logic [31:0] D1_Instruction;
    logic [31:0] D1_PCAdd4;
    logic        D1_F2IsBDS;
    logic        D1_F2Exception;
    logic        D1_XOP_Restart;
    logic [4:0]  D1_F2ExcCode;
    logic [31:0] D1_FetchPC;
    logic        F2_QueueFull;
    logic [2:0]  D1_Count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] q[$];

    d1_fetch_queue #(.DEPTH(4), .RESET_PC(32'hBFC00000)) dut (
        .clock(clock), .reset(reset),
        .F2_Issued(F2_Issued), .F2_Instruction(F2_Instruction), .F2_FetchPC(F2_FetchPC),
        .F2_PCAdd4(F2_PCAdd4), .F2_IsBDS(F2_IsBDS), .F2_Exception(F2_Exception),
        .F2_XOP_Restart(F2_XOP_Restart), .F2_ExcCode(F2_ExcCode),
        .D1_Stall(D1_Stall), .D1_Flush(D1_Flush),
        .D1_F2Issued(D1_F2Issued), .D1_Instruction(D1_Instruction), .D1_PCAdd4(D1_PCAdd4),
        .D1_F2IsBDS(D1_F2IsBDS), .D1_F2Exception(D1_F2Exception), .D1_XOP_Restart(D1_XOP_Restart),
        .D1_F2ExcCode(D1_F2ExcCode), .D1_FetchPC(D1_FetchPC),
        .F2_QueueFull(F2_QueueFull), .D1_Count(D1_Count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic bds, input logic [31:0] ins);
        F2_Issued      = v;
        F2_FetchPC     = pc;
        F2_PCAdd4      = pc + 32'd4;
        F2_IsBDS       = bds;
        F2_Instruction = ins;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        F2_Exception = 1'b0; F2_XOP_Restart = 1'b0; F2_ExcCode = 5'd0;
        D1_Stall = 1'b0; D1_Flush = 1'b0;
        #1;
        chk("rst_issued", 32'(D1_F2Issued), 32'd0);
        chk("rst_full",   32'(F2_QueueFull), 32'd0);
        chk("rst_count",  32'(D1_Count), 32'd0);
        chk("rst_pc",     D1_FetchPC, 32'hBFC00000);
        chk("rst_instr",  D1_Instruction, 32'd0);
        chk("rst_pcadd4", D1_PCAdd4, 32'd0);
        step();
        reset = 1'b0;
        step();

        // Fill with stall, overflow push dropped, then drain in order.
        D1_Stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 1'b0, 32'hA0000000 + 32'(i));
            F2_Exception = i[0]; F2_XOP_Restart = i[1]; F2_ExcCode = 5'(i + 8);
            step();
        end
        chk("fill_count", 32'(D1_Count), 32'd4);
        chk("fill_full",  32'(F2_QueueFull), 32'd1);
        chk("fill_head",  D1_FetchPC, 32'h100);
        drive(1'b1, 32'h110, 1'b0, 32'hA0000004);
        F2_Exception = 1'b0; F2_XOP_Restart = 1'b0; F2_ExcCode = 5'd0;
        step();
        chk("drop_count", 32'(D1_Count), 32'd4);
        chk("drop_head",  D1_FetchPC, 32'h100);
        chk("drop_instr", D1_Instruction, 32'hA0000000);
        F2_Issued = 1'b0; D1_Stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("drain_pc",     D1_FetchPC, 32'h100 + 32'(4 * k));
            chk("drain_instr",  D1_Instruction, 32'hA0000000 + 32'(k));
            chk("drain_pcadd4", D1_PCAdd4, 32'h104 + 32'(4 * k));
            chk("drain_exc",    32'(D1_F2Exception), 32'(k % 2));
            chk("drain_xop",    32'(D1_XOP_Restart), 32'((k / 2) % 2));
            chk("drain_code",   32'(D1_F2ExcCode), 32'(k + 8));
            step();
        end
        chk("empty_issued", 32'(D1_F2Issued), 32'd0);
        chk("empty_count",  32'(D1_Count), 32'd0);
        chk("empty_pc",     D1_FetchPC, 32'h10C);
        chk("empty_instr",  D1_Instruction, 32'd0);

`ifdef D1_FETCH_QUEUE_BYPASS_EN
        drive(1'b1, 32'h400, 1'b0, 32'hC0000400);
        #1;
        chk("byp_issued", 32'(D1_F2Issued), 32'd1);
        chk("byp_instr",  D1_Instruction, 32'hC0000400);
        chk("byp_pc",     D1_FetchPC, 32'h400);
        step();
        chk("byp_count", 32'(D1_Count), 32'd0);
        F2_Issued = 1'b0;
        #1;
        chk("byp_empty", 32'(D1_F2Issued), 32'd0);
        chk("byp_last",  D1_FetchPC, 32'h400);
        D1_Stall = 1'b1;
        drive(1'b1, 32'h404, 1'b1, 32'hC0000404);
        #1;
        chk("byps_pc", D1_FetchPC, 32'h400);
        step();
        chk("byps_count", 32'(D1_Count), 32'd1);
        chk("byps_instr", D1_Instruction, 32'hC0000404);
        F2_Issued = 1'b0; D1_Stall = 1'b0;
        step();
`else
        D1_Stall = 1'b1;
        drive(1'b1, 32'h180, 1'b0, 32'hB0000180);
        #1;
        chk("lat_before", 32'(D1_F2Issued), 32'd0);
        chk("lat_before_pc", D1_FetchPC, 32'h10C);
        step();
        chk("lat_after",   32'(D1_F2Issued), 32'd1);
        chk("lat_pc",      D1_FetchPC, 32'h180);
        chk("lat_count",   32'(D1_Count), 32'd1);
        F2_Issued = 1'b0; D1_Stall = 1'b0;
        step();
`endif
        chk("pre_wrap_count", 32'(D1_Count), 32'd0);

        // Full queue with simultaneous push and pop across pointer wrap.
        D1_Stall = 1'b1;
        q.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h1000 + 32'(4 * i), 1'b0, (32'h1000 + 32'(4 * i)) ^ 32'hFFFF0000);
            q.push_back(32'h1000 + 32'(4 * i));
            step();
        end
        D1_Stall = 1'b0;
        for (int n = 0; n < 10; n++) begin
            drive(1'b1, 32'h1010 + 32'(4 * n), 1'b0, (32'h1010 + 32'(4 * n)) ^ 32'hFFFF0000);
            chk("wrap_pc",    D1_FetchPC, q[0]);
            chk("wrap_instr", D1_Instruction, q[0] ^ 32'hFFFF0000);
            void'(q.pop_front());
            q.push_back(32'h1010 + 32'(4 * n));
            step();
            chk("wrap_count", 32'(D1_Count), 32'd4);
        end
        F2_Issued = 1'b0;
        for (int n = 0; n < 4; n++) begin
            chk("wrap_drain", D1_FetchPC, q[0]);
            void'(q.pop_front());
            step();
        end
        chk("wrap_empty", 32'(D1_Count), 32'd0);

        // Branch / delay slot restart PC.
        D1_Stall = 1'b1;
        drive(1'b1, 32'h200, 1'b0, 32'h11111111); step();
        drive(1'b1, 32'h204, 1'b1, 32'h22222222); step();
        drive(1'b1, 32'h300, 1'b0, 32'h33333333); step();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        D1_Stall = 1'b0;
        chk("br_pc",  D1_FetchPC, 32'h200);
        chk("br_bds", 32'(D1_F2IsBDS), 32'd0);
        step();
        chk("bds_pc",     D1_FetchPC, 32'h200);
        chk("bds_flag",   32'(D1_F2IsBDS), 32'd1);
        chk("bds_instr",  D1_Instruction, 32'h22222222);
        chk("bds_pcadd4", D1_PCAdd4, 32'h208);
        step();
        chk("nb_pc", D1_FetchPC, 32'h300);
        step();
        chk("br_empty", 32'(D1_Count), 32'd0);

        // Flush overrides stall and discards same-cycle push.
        D1_Stall = 1'b1;
        drive(1'b1, 32'h500, 1'b0, 32'h55555500); step();
        drive(1'b1, 32'h504, 1'b0, 32'h55555504); step();
        drive(1'b1, 32'h508, 1'b0, 32'h55555508); step();
        chk("fl_pre_count", 32'(D1_Count), 32'd3);
        D1_Flush = 1'b1;
        drive(1'b1, 32'h600, 1'b0, 32'h66666600);
        step();
        chk("fl_count",  32'(D1_Count), 32'd0);
        chk("fl_issued", 32'(D1_F2Issued), 32'd0);
        chk("fl_pc",     D1_FetchPC, 32'h508);
        chk("fl_full",   32'(F2_QueueFull), 32'd0);
        D1_Flush = 1'b0; F2_Issued = 1'b0;
        step();
        chk("fl_post_count", 32'(D1_Count), 32'd0);
        chk("fl_post_pc",    D1_FetchPC, 32'h508);

        // Reset mid-stream.
        drive(1'b1, 32'h700, 1'b0, 32'h77777700); step();
        drive(1'b1, 32'h704, 1'b0, 32'h77777704); step();
        F2_Issued = 1'b0;
        chk("mr_pre_count", 32'(D1_Count), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("mr_count",  32'(D1_Count), 32'd0);
        chk("mr_issued", 32'(D1_F2Issued), 32'd0);
        chk("mr_pc",     D1_FetchPC, 32'hBFC00000);
        chk("mr_instr",  D1_Instruction, 32'd0);
        chk("mr_full",   32'(F2_QueueFull), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        step();
        chk("mr_post_count", 32'(D1_Count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
